seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed driver for the two-digit common-anode 7-segment display, which shows a 4-bit value (0–15) in decimal on a shared segment bus.
- Accepts new values over a valid/ready handshake.
- Commits a new value only at frame boundaries, so a frame never shows a mix of old and new digits.
- Scans ones digit, gap, tens digit, gap, with blank gaps to suppress ghosting.
- Sits between the control logic producing the value and the board display pins.

Parameters:
DWELL, 50000, cycles each digit is lit per frame (>=1)
GAP, 100, blank cycles after each digit (>=1)
CW, $clog2(max(DWELL,GAP)+1), phase counter width (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ld_valid  input  1  new value offered
ld_data  input  4  value to display, unsigned 0–15
ld_ready  output  1  block can accept a value this cycle
seg  output  7  shared segments {a,b,c,d,e,f,g}, a = MSB, active-low (0 = lit)
an  output  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit
frame_tick  output  1  one-cycle pulse on the last cycle of each frame
cur_value  output  4  value currently being displayed

Behaviour:
- Clock and reset: single clock domain, one clock. Reset is synchronous and active-high.
- Reset state:
  - state = S_D0, phase counter = 0, cur_value = 0, pending buffer empty.
  - Outputs: an = 2'b10, seg = 7'b0000001, ld_ready = 1, frame_tick = 0.
- FSM sequence: S_D0 (DWELL cycles) -> S_G0 (GAP) -> S_D1 (DWELL) -> S_G1 (GAP) -> S_D0.
  - Counter increments each cycle.
  - On count == duration-1, the counter clears and the state advances.
  - Frame length = 2*(DWELL+GAP) cycles.
- Outputs are Moore, combinational from registered state and cur_value:
  - S_D0: an = 10, seg = ones pattern.
  - S_D1: an = 01, seg = tens pattern.
  - S_G0 / S_G1: an = 11, seg = 1111111.
- Digit arithmetic: values 0–9 give tens = blank, ones = value; values 10–15 give tens = 1, ones = value-10.
- Ones segment patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
- Tens segment patterns: blank = 1111111; "1" = 1001111.
- Handshake:
  - ld_ready = !pend_valid.
  - Transfer occurs when ld_valid && ld_ready: pend <= ld_data, pend_valid <= 1.
  - ld_data is ignored when no transfer occurs.
- Commit:
  - Happens on the final S_G1 cycle, the same cycle frame_tick = 1, when pend_valid = 1.
  - cur_value <= pend and pend_valid <= 0.
  - The new value is visible from the next S_D0, which is the first cycle of the new frame.
  - ld_ready returns to 1 on the cycle after the commit.
- Accept and commit can never coincide (ready is 0 whenever pend is full).
- A second offer while pending is stalled, not dropped or overwritten.
- Reset mid-frame: FSM restarts at S_D0 count 0, any pending value is discarded, cur_value = 0.
- Reset has priority over all other events in the same cycle.
- No combinational path from ld_valid to ld_ready.

Optional Feature:
Macro: LAMP_TEST_EN.
- Defined:
  - Adds input port lamp_test (1 bit).
  - While lamp_test = 1, seg = 7'b0000000 during S_D0 and S_D1.
  - Gaps stay blank.
  - Scan timing, handshake and cur_value are unaffected.
  - Deasserting lamp_test restores normal patterns immediately.
- Undefined: no lamp_test port and no lamp-test logic.

Test Plan:
(All with DWELL=4, GAP=2, frame = 12 cycles.)
- Reset, then idle for 12 cycles:
  - Cycles 0–3: an=10, seg=0000001.
  - Cycles 4–5: an=11, seg=1111111.
  - Cycles 6–9: an=01, seg=1111111.
  - Cycles 10–11: gap.
  - frame_tick=1 only at cycle 11.
- Offer 13 at cycle 3:
  - ld_ready=0 from cycle 4.
  - cur_value stays 0 through cycle 11.
  - From cycle 12: ones seg=0000110 and tens seg=1001111.
  - ld_ready=1 at cycle 12.
- Offer 7 while 13 is still pending:
  - ld_valid is held and no transfer occurs until ld_ready rises.
  - 7 is accepted at cycle 12.
  - 7 is displayed from cycle 24: seg=0001111 on ones, tens blank.
- Sweep all 16 values, one per frame:
  - Ones/tens patterns match the tables for 0–15.
  - Value 10 gives ones=0000001, tens=1001111.
  - Value 15 gives ones=0100100, tens=1001111.
- Assert rst at cycle 7 (in S_D1) with a value pending:
  - Next cycle: an=10, seg=0000001, ld_ready=1, cur_value=0.
  - Frame timing restarts from count 0.
- With LAMP_TEST_EN defined, lamp_test=1 while value 5 is displayed:
  - seg=0000000 in both digit phases and 1111111 in the gaps.
  - Releasing lamp_test shows ones=0100100 again.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit common-anode 7-segment scan driver for a 4-bit value
// shown in decimal. New values are accepted over valid/ready and committed
// only at frame boundaries.
// Optional feature macro: LAMP_TEST_EN (adds lamp_test input that lights all
// segments during digit phases).
module seg_scan_ctrl #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GAP   = 100
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  input  logic       ld_valid,
  input  logic [3:0] ld_data,
  output logic       ld_ready,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick,
  output logic [3:0] cur_value
);

  localparam int unsigned MAXD = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {S_D0, S_G0, S_D1, S_G1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    cur_q, cur_d;
  logic          last_c;
  logic          ld_ready_q;
  logic          tick_q;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // Segment pattern for a single decimal digit 0-9, active-low {a..g}
  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0000001;
      4'd1:    p = 7'b1001111;
      4'd2:    p = 7'b0010010;
      4'd3:    p = 7'b0000110;
      4'd4:    p = 7'b1001100;
      4'd5:    p = 7'b0100100;
      4'd6:    p = 7'b0100000;
      4'd7:    p = 7'b0001111;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0001100;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Phase sequencing, handshake buffer and frame-boundary commit
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cur_d        = cur_q;
    last_c       = 1'b0;
    case (state_q)
      S_D0, S_D1: last_c = (cnt_q == CW'(DWELL - 1));
      default:    last_c = (cnt_q == CW'(GAP - 1));
    endcase
    if (last_c) begin
      cnt_d = '0;
      case (state_q)
        S_D0:    state_d = S_G0;
        S_G0:    state_d = S_D1;
        S_D1:    state_d = S_G1;
        default: state_d = S_D0;
      endcase
    end
    // Ready is low whenever pend is full, so commit and accept are exclusive
    if (last_c && (state_q == S_G1) && pend_valid_q) begin
      cur_d        = pend_q;
      pend_valid_d = 1'b0;
    end else if (ld_valid && !pend_valid_q) begin
      pend_d       = ld_data;
      pend_valid_d = 1'b1;
    end
  end

  // Display decode for the upcoming cycle so the outputs come straight from flops
  always_comb begin
    an_d  = 2'b11;
    seg_d = 7'b1111111;
    case (state_d)
      S_D0: begin
        an_d  = 2'b10;
        seg_d = digit_pat((cur_d >= 4'd10) ? cur_d - 4'd10 : cur_d);
      end
      S_D1: begin
        an_d  = 2'b01;
        seg_d = (cur_d >= 4'd10) ? 7'b1001111 : 7'b1111111;
      end
      default: begin
        an_d  = 2'b11;
        seg_d = 7'b1111111;
      end
    endcase
  end

  // State, datapath and registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_D0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cur_q        <= '0;
      ld_ready_q   <= 1'b1;
      tick_q       <= 1'b0;
      an_q         <= 2'b10;
      seg_q        <= 7'b0000001;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cur_q        <= cur_d;
      ld_ready_q   <= !pend_valid_d;
      tick_q       <= (state_d == S_G1) && (cnt_d == CW'(GAP - 1));
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign ld_ready   = ld_ready_q;
  assign frame_tick = tick_q;
  assign cur_value  = cur_q;
  assign an         = an_q;

`ifdef LAMP_TEST_EN
  // Lamp test overrides the digit phases only and takes effect without delay
  assign seg = (lamp_test && (an_q != 2'b11)) ? 7'b0000000 : seg_q;
`else
  assign seg = seg_q;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DWELL=4, GAP=2 (12-cycle frame).
module tb_seg_scan_ctrl;

  localparam int unsigned DWELL = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned FRAME = 2 * (DWELL + GAP);

  localparam logic [6:0] ONES_PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lamp_test = 1'b0;
  logic       ld_valid = 1'b0;
  logic [3:0] ld_data = 4'd0;
  logic       ld_ready;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic [3:0] cur_value;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: position in frame, displayed value, one-deep pending slot
  int         m_t = 0;
  int         m_cur = 0;
  bit         m_pv = 1'b0;
  int         m_pend = 0;

  seg_scan_ctrl #(.DWELL(DWELL), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .cur_value  (cur_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model update at each active edge from the inputs the DUT samples
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_cur = 0; m_pv = 1'b0;
    end else begin
      if ((m_t % FRAME) == FRAME - 1 && m_pv) begin
        m_cur = m_pend; m_pv = 1'b0;
      end else if (ld_valid && !m_pv) begin
        m_pend = int'(ld_data); m_pv = 1'b1;
      end
      m_t++;
    end
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    if (chk_en) begin
      int         p;
      logic [1:0] e_an;
      logic [6:0] e_seg;
      p = m_t % FRAME;
      if (p < DWELL) begin
        e_an = 2'b10; e_seg = ONES_PAT[m_cur % 10];
      end else if (p >= DWELL + GAP && p < 2 * DWELL + GAP) begin
        e_an = 2'b01; e_seg = (m_cur / 10 == 1) ? 7'b1001111 : 7'b1111111;
      end else begin
        e_an = 2'b11; e_seg = 7'b1111111;
      end
`ifdef LAMP_TEST_EN
      if (lamp_test && e_an != 2'b11) e_seg = 7'b0000000;
`endif
      chk("model_an", 7'(an), 7'(e_an));
      chk("model_seg", seg, e_seg);
      chk("model_ready", 7'(ld_ready), 7'(!m_pv));
      chk("model_tick", 7'(frame_tick), 7'(p == FRAME - 1));
      chk("model_cur", 7'(cur_value), 7'(m_cur));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle frame with offer of 13 at cycle 3, then 7 held while 13 pends
    for (int c = 0; c < 36; c++) begin
      case (c)
        0: begin
          chk("lit_rst_an", 7'(an), 7'(2'b10));
          chk("lit_rst_seg", seg, 7'b0000001);
          chk("lit_rst_ready", 7'(ld_ready), 7'd1);
          chk("lit_rst_tick", 7'(frame_tick), 7'd0);
        end
        4: begin
          chk("lit_c4_an", 7'(an), 7'(2'b11));
          chk("lit_c4_ready", 7'(ld_ready), 7'd0);
        end
        6: begin
          chk("lit_c6_an", 7'(an), 7'(2'b01));
          chk("lit_c6_seg", seg, 7'b1111111);
        end
        11: begin
          chk("lit_c11_tick", 7'(frame_tick), 7'd1);
          chk("lit_c11_cur", 7'(cur_value), 7'd0);
        end
        12: begin
          chk("lit_13_ones", seg, 7'b0000110);
          chk("lit_13_ready", 7'(ld_ready), 7'd1);
          chk("lit_13_cur", 7'(cur_value), 7'd13);
        end
        13: chk("lit_7_accepted", 7'(ld_ready), 7'd0);
        18: chk("lit_13_tens", seg, 7'b1001111);
        24: begin
          chk("lit_7_ones", seg, 7'b0001111);
          chk("lit_7_cur", 7'(cur_value), 7'd7);
        end
        30: chk("lit_7_tens", seg, 7'b1111111);
        default: ;
      endcase
      if (c == 3) begin ld_valid = 1'b1; ld_data = 4'd13; end
      if (c == 4) ld_data = 4'd7;
      if (c == 13) ld_valid = 1'b0;
      next_cycle();
    end

    // Sweep all 16 values, one per frame
    for (int f = 0; f < 17; f++) begin
      for (int p = 0; p < 12; p++) begin
        if (f == 11 && p == 0) chk("lit_10_ones", seg, 7'b0000001);
        if (f == 11 && p == 6) chk("lit_10_tens", seg, 7'b1001111);
        if (f == 16 && p == 0) chk("lit_15_ones", seg, 7'b0100100);
        if (f == 16 && p == 6) chk("lit_15_tens", seg, 7'b1001111);
        ld_valid = (p == 0) && (f < 16);
        ld_data  = 4'(f);
        next_cycle();
      end
    end
    ld_valid = 1'b0;

    // Reset in S_D1 with a value pending
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin ld_valid = 1'b1; ld_data = 4'd9; end
      if (c == 3) ld_valid = 1'b0;
      if (c == 7) begin
        chk("lit_pre_rst_ready", 7'(ld_ready), 7'd0);
        rst = 1'b1;
      end
      next_cycle();
    end
    rst = 1'b0;
    chk("lit_mid_rst_an", 7'(an), 7'(2'b10));
    chk("lit_mid_rst_seg", seg, 7'b0000001);
    chk("lit_mid_rst_ready", 7'(ld_ready), 7'd1);
    chk("lit_mid_rst_cur", 7'(cur_value), 7'd0);
    repeat (11) next_cycle();
    chk("lit_mid_rst_tick", 7'(frame_tick), 7'd1);

`ifdef LAMP_TEST_EN
    // Lamp test over value 5
    ld_valid = 1'b1; ld_data = 4'd5;
    next_cycle();
    ld_valid = 1'b0;
    repeat (12) next_cycle();
    lamp_test = 1'b1;
    #1;
    chk("lit_lamp_d0", seg, 7'b0000000);
    repeat (4) next_cycle();
    chk("lit_lamp_gap", seg, 7'b1111111);
    repeat (2) next_cycle();
    chk("lit_lamp_d1", seg, 7'b0000000);
    repeat (6) next_cycle();
    lamp_test = 1'b0;
    #1;
    chk("lit_lamp_off", seg, 7'b0100100);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_data  = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 79) == 0);
`ifdef LAMP_TEST_EN
      lamp_test = ($urandom_range(0, 9) == 0);
`endif
      next_cycle();
    end
    rst = 1'b0;
    ld_valid = 1'b0;
    lamp_test = 1'b0;
    next_cycle();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
